univ_shift_reg: RTL

//   Parametrised universal shift register, successor to the 4-bit load/shift-left/shift-right register.

---
 rtl/univ_shift_reg.sv | 110 +++++++++++
 1 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register with eight IDLE modes and a burst engine.
// A burst performs N back-to-back shifts from one start pulse. All state changes on the falling clock edge.
module univ_shift_reg #(
  parameter int                 WIDTH     = 4,
  parameter int                 CNT_W     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] p_in,
  input  logic             left_shift_inp,
  input  logic             right_shift_inp,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] shift_cnt,
  output logic [WIDTH-1:0] p_out,
  output logic             ser_out_msb,
  output logic             ser_out_lsb,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   p_q, p_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   shl_val;
  logic [WIDTH-1:0]   shr_val;

  assign shl_val = {p_q[WIDTH-2:0], left_shift_inp};
  assign shr_val = {right_shift_inp, p_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // start outranks mode/en; a zero-length burst completes immediately
        if (start) begin
          if (shift_cnt != '0) begin
            dir_d   = dir;
            cnt_d   = shift_cnt;
            busy_d  = 1'b1;
            state_d = BURST;
          end else begin
            done_d = 1'b1;
          end
        end else if (en) begin
          case (mode)
            3'b000:  p_d = p_q;
            3'b001:  p_d = shl_val;
            3'b010:  p_d = shr_val;
            3'b011:  p_d = p_in;
            3'b100:  p_d = {p_q[WIDTH-2:0], p_q[WIDTH-1]};
            3'b101:  p_d = {p_q[0], p_q[WIDTH-1:1]};
            3'b110:  p_d = {p_q[WIDTH-1], p_q[WIDTH-1:1]};
            default: p_d = '0;
          endcase
        end
      end
      BURST: begin
        p_d = dir_q ? shr_val : shl_val;
        if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= RESET_VAL;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign p_out       = p_q;
  assign ser_out_msb = p_q[WIDTH-1];
  assign ser_out_lsb = p_q[0];
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
